hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline sequencing controller for the five-stage core. It produces per-stage stall and flush strobes and the execute-stage forwarding selects, consuming register indices from decode, execute, memory and writeback. It also runs a start-up bubble sequence, because the decode and execute pipeline registers are not reset, and a data-memory wait/timeout state machine. It exposes saturating stall and flush performance counters.

## Interface
Parameters:
- INIT_CYCLES, 2, cycles of forced pipeline flush after reset release (≥1)
- MAX_WAIT, 64, consecutive dmem_busy cycles that trigger the timeout (≥2)
- CNT_WIDTH, 32, width of the performance counters

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high
- rs1_d, rs2_d  in  5  source registers of the instruction in decode
- rs1_e, rs2_e, rd_e  in  5  source and destination registers in execute
- res_src_e  in  2  result source in execute; 2'b01 = load
- pc_src_e  in  1  taken branch or jump resolved in execute
- rd_m  in  5  destination in memory; reg_write_m  in  1  its write enable
- rd_w  in  5  destination in writeback; reg_write_w  in  1  its write enable
- dmem_busy  in  1  data memory not ready this cycle
- err_clr  in  1  clears the timeout error
- stall_f, stall_d, stall_e, stall_m, stall_w  out  1  hold the stage register
- flush_d, flush_e  out  1  load a bubble into the stage register
- forward_a_e, forward_b_e  out  2  ALU operand select: 00 register file, 01 writeback result, 10 memory-stage ALU result
- timeout_err  out  1  sticky memory timeout flag
- stall_cycles, flush_count  out  CNT_WIDTH  performance counters
- state  out  2  INIT=00, RUN=01, MEM_WAIT=10, ERROR=11

## Operation
- Forwarding is combinational and independent of state:
  - forward_a_e = 10 if reg_write_m && rd_m!=0 && rd_m==rs1_e.
  - Otherwise 01 if reg_write_w && rd_w!=0 && rd_w==rs1_e.
  - Otherwise 00.
  - forward_b_e uses rs2_e the same way. The memory stage wins over writeback.
- lw_stall = (res_src_e==01) && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- freeze = stall_f = stall_d = stall_e = stall_m = stall_w. All five are driven together whenever freeze applies.
- FSM states:
  - INIT: flush_d = flush_e = 1, stall_f = 1, all other stalls 0. A counter runs 0..INIT_CYCLES-1, then the FSM goes to RUN.
  - RUN, priority order:
    1. dmem_busy → freeze, no flush; the FSM goes to MEM_WAIT with the wait counter at 1.
    2. Else pc_src_e → flush_d = flush_e = 1, no stalls.
    3. Else lw_stall → stall_f = stall_d = 1 and flush_e = 1.
    4. Else all 0.
  - MEM_WAIT:
    - While dmem_busy: freeze and increment the wait counter.
    - When dmem_busy is high and the counter == MAX_WAIT-1, go to ERROR.
    - When dmem_busy is low, the freeze drops in the same cycle and RUN priorities 2–4 apply; go to RUN.
  - ERROR: freeze unconditionally and timeout_err = 1. err_clr sampled high → RUN with the wait counter cleared.
- A taken branch beats a load-use hazard because the decode instruction is on the wrong path.
- The branch redirect stays pending during a freeze: execute is held, so pc_src_e remains asserted and the flush fires on the first unfrozen cycle.
- stall_cycles increments in every cycle with stall_f=1 in RUN, MEM_WAIT or ERROR. Cycles in INIT and reset cycles do not count.
- flush_count increments in every cycle where priority 2 fires.
- Both counters saturate at all-ones.

## Timing
- While rst is high:
  - flush_d = flush_e = 1 and stall_f = 1.
  - stall_d/e/m/w = 0 and forwards = 00.
  - timeout_err = 0, counters = 0, state = INIT.
- On the first cycle after release the FSM is INIT with the counter at 0. It reaches RUN exactly INIT_CYCLES edges later.
- Stall, flush and forward outputs are combinational from registered state plus the current inputs, with zero cycles of latency. State and counters update on the rising edge.
- Timeout: dmem_busy held high for MAX_WAIT consecutive cycles, counted from the first busy cycle in RUN, gives state = ERROR on the next edge. timeout_err goes high in that next cycle.
- err_clr is ignored outside ERROR. Leaving ERROR takes 1 cycle, and timeout_err is 0 in the RUN cycle.
- rst asserted mid-MEM_WAIT or mid-ERROR returns the block to INIT at the next edge, overriding err_clr.

## Test plan
- Reset then idle, INIT_CYCLES=2 → flush_d/flush_e high for 2 cycles after release, then state=01 and all strobes 0.
- rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1, rs1_e=5, rs2_e=0 → forward_a_e=10, forward_b_e=00. With rd_m=0 the result is forward_a_e=01.
- res_src_e=01, rd_e=7, rs2_d=7 → one cycle of stall_f=stall_d=flush_e=1 and stall_cycles+1. Adding pc_src_e=1 in the same cycle gives flush_d=flush_e=1 with no stall, and flush_count+1.
- dmem_busy high for 3 cycles → all stalls high exactly 3 cycles, state=10 in cycles 2–3, RUN after. pc_src_e held through the freeze → flush in the first unfrozen cycle.
- MAX_WAIT=4, dmem_busy held high → state=11 after 4 busy cycles with timeout_err=1 and the freeze persisting. err_clr pulse → RUN and timeout_err=0. A reset during ERROR → INIT.
- Force stall_cycles near all-ones, then keep stalling → the counter holds at all-ones.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush strobes, execute-stage forwarding,
// start-up bubble sequence, data-memory wait/timeout FSM and saturating perf counters.
module hazard_ctrl #(
   parameter int unsigned INIT_CYCLES = 2,
   parameter int unsigned MAX_WAIT    = 64,
   parameter int unsigned CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4:0]           rs1_d,
   input  logic [4:0]           rs2_d,
   input  logic [4:0]           rs1_e,
   input  logic [4:0]           rs2_e,
   input  logic [4:0]           rd_e,
   input  logic [1:0]           res_src_e,
   input  logic                 pc_src_e,
   input  logic [4:0]           rd_m,
   input  logic                 reg_write_m,
   input  logic [4:0]           rd_w,
   input  logic                 reg_write_w,
   input  logic                 dmem_busy,
   input  logic                 err_clr,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 stall_e,
   output logic                 stall_m,
   output logic                 stall_w,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic [1:0]           forward_a_e,
   output logic [1:0]           forward_b_e,
   output logic                 timeout_err,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] flush_count,
   output logic [1:0]           state
);

   localparam int unsigned INIT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT);

   typedef enum logic [1:0] {
      S_INIT     = 2'b00,
      S_RUN      = 2'b01,
      S_MEM_WAIT = 2'b10,
      S_ERROR    = 2'b11
   } state_t;

   state_t              state_q;
   logic [INIT_W-1:0]   init_cnt;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                lw_stall;
   logic                freeze;
   logic                branch_fire;

   assign state = state_q;

   // Memory stage result is newer than writeback, so it wins.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rdm, input logic wm,
                                          input logic [4:0] rdw, input logic ww);
      logic [1:0] sel;
      sel = 2'b00;
      if (wm && (rdm != 5'd0) && (rdm == rs))
         sel = 2'b10;
      else if (ww && (rdw != 5'd0) && (rdw == rs))
         sel = 2'b01;
      return sel;
   endfunction

   assign lw_stall = (res_src_e == 2'b01) && (rd_e != 5'd0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));

   // Strobes are combinational from registered state plus current inputs.
   always_comb begin
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      stall_e     = 1'b0;
      stall_m     = 1'b0;
      stall_w     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      forward_a_e = 2'b00;
      forward_b_e = 2'b00;
      freeze      = 1'b0;
      branch_fire = 1'b0;
      if (rst) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
         stall_f = 1'b1;
      end else begin
         forward_a_e = fwd_sel(rs1_e, rd_m, reg_write_m, rd_w, reg_write_w);
         forward_b_e = fwd_sel(rs2_e, rd_m, reg_write_m, rd_w, reg_write_w);
         case (state_q)
            S_INIT: begin
               flush_d = 1'b1;
               flush_e = 1'b1;
               stall_f = 1'b1;
            end
            S_RUN, S_MEM_WAIT: begin
               if (dmem_busy) begin
                  freeze = 1'b1;
               end else if (pc_src_e) begin
                  branch_fire = 1'b1;
               end else if (lw_stall) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
               end
            end
            S_ERROR: freeze = 1'b1;
            default: freeze = 1'b1;
         endcase
         if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
         end
         if (branch_fire) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
         end
      end
   end

   // FSM, wait/init counters, sticky error and saturating counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_INIT;
         init_cnt     <= '0;
         wait_cnt     <= '0;
         timeout_err  <= 1'b0;
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_f && (state_q != S_INIT) && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
         if (branch_fire && (flush_count != '1))
            flush_count <= flush_count + CNT_WIDTH'(1);
         case (state_q)
            S_INIT: begin
               if (init_cnt == INIT_W'(INIT_CYCLES - 1)) begin
                  state_q  <= S_RUN;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + INIT_W'(1);
               end
            end
            S_RUN: begin
               if (dmem_busy) begin
                  state_q  <= S_MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            S_MEM_WAIT: begin
               if (dmem_busy) begin
                  if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                     state_q     <= S_ERROR;
                     timeout_err <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end else begin
                  state_q  <= S_RUN;
                  wait_cnt <= '0;
               end
            end
            S_ERROR: begin
               if (err_clr) begin
                  state_q     <= S_RUN;
                  wait_cnt    <= '0;
                  timeout_err <= 1'b0;
               end
            end
            default: state_q <= S_INIT;
         endcase
      end
   end

endmodule
